// File: rtl/tlb_defs.sv
// tlb_defs: shared FSM state encodings and TLB entry field layout.
package tlb_defs;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WALK  = 2'd2,
    RESP  = 2'd3
  } state_t;
  // Entry layout, LSB first: present, valid, pfn, vpn.
  localparam int ENT_PRESENT = 0;
  localparam int ENT_VALID   = 1;
  localparam int ENT_PFN_LSB = 2;
  function automatic int ent_vpn_lsb(input int pfn_w);
    return ENT_PFN_LSB + pfn_w;
  endfunction
  function automatic int ent_w(input int vpn_w, input int pfn_w);
    return ent_vpn_lsb(pfn_w) + vpn_w;
  endfunction
endpackage

// File: rtl/tlb_entry_match.sv
// tlb_entry_match: hit detection for one TLB entry against the looked-up VPN.
module tlb_entry_match #(
  parameter int VPN_W = 20
) (
  input  logic [VPN_W-1:0] entry_vpn,
  input  logic             valid,
  input  logic             present,
  input  logic [VPN_W-1:0] vpn,
  output logic             hit
);
  assign hit = valid & present & (entry_vpn == vpn);
endmodule

// File: rtl/tlb_lookup_fill.sv
// tlb_lookup_fill: fully associative TLB with segment-limit check, page-walk fill and flush.
module tlb_lookup_fill
  import tlb_defs::*;
#(
  parameter int ENTRIES = 8,
  parameter int VPN_W   = 20,
  parameter int PFN_W   = 3,
  parameter int LIMIT_W = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [VPN_W-1:0]   req_vpn,
  input  logic [31:0]        req_off,
  input  logic [LIMIT_W-1:0] seg_limit,
  input  logic               flush,
  output logic               walk_req,
  output logic [VPN_W-1:0]   walk_vpn,
  input  logic               walk_ack,
  input  logic [PFN_W-1:0]   walk_pfn,
  input  logic               walk_fault,
  output logic               resp_valid,
  output logic [PFN_W-1:0]   resp_pfn,
  output logic               resp_page_fault,
  output logic               resp_prot_exp
);
  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int VPN_LSB = ent_vpn_lsb(PFN_W);
  localparam int EW      = ent_w(VPN_W, PFN_W);
  state_t state, next_state;
  logic [EW-1:0] ent [ENTRIES];
  logic [ENTRIES-1:0] hits;
  logic [IDX_W-1:0] rr, hit_idx, victim;
  logic [VPN_W-1:0] vpn_q;
  logic [31:0] off_q;
  logic [LIMIT_W-1:0] lim_q;
  logic [PFN_W-1:0] pfn_q, hit_pfn;
  logic pf_q, pe_q, drop, any_hit, any_free, prot, fill;
  for (genvar i = 0; i < ENTRIES; i++) begin : g_match
    tlb_entry_match #(.VPN_W(VPN_W)) u_match (
      .entry_vpn (ent[i][VPN_LSB +: VPN_W]),
      .valid     (ent[i][ENT_VALID]),
      .present   (ent[i][ENT_PRESENT]),
      .vpn       (vpn_q),
      .hit       (hits[i])
    );
  end
  // Descending scan so the lowest matching / free index is the one that sticks.
  always_comb begin
    hit_idx  = '0;
    any_hit  = 1'b0;
    victim   = rr;
    any_free = 1'b0;
    for (int k = ENTRIES - 1; k >= 0; k--) begin
      if (hits[k]) begin
        hit_idx = IDX_W'(k);
        any_hit = 1'b1;
      end
      if (!ent[k][ENT_VALID]) begin
        victim   = IDX_W'(k);
        any_free = 1'b1;
      end
    end
  end
  assign hit_pfn = ent[hit_idx][ENT_PFN_LSB +: PFN_W];
  // off_q already has its low five bits forced high at capture.
  assign prot = off_q > 32'(lim_q);
  assign fill = (state == WALK) && walk_ack && !walk_fault && !drop && !flush;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = req_valid ? CHECK : IDLE;
      CHECK:   next_state = (prot || any_hit) ? RESP : WALK;
      WALK:    next_state = walk_ack ? RESP : WALK;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    req_ready       = state == IDLE;
    walk_req        = state == WALK;
    resp_valid      = state == RESP;
    walk_vpn        = walk_req ? vpn_q : '0;
    resp_pfn        = resp_valid ? pfn_q : '0;
    resp_page_fault = resp_valid & pf_q;
    resp_prot_exp   = resp_valid & pe_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr    <= '0;
      drop  <= 1'b0;
      pfn_q <= '0;
      pf_q  <= 1'b0;
      pe_q  <= 1'b0;
      vpn_q <= '0;
      off_q <= '0;
      lim_q <= '0;
      for (int k = 0; k < ENTRIES; k++) ent[k][ENT_VALID] <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        vpn_q <= req_vpn;
        off_q <= req_off | 32'h1f;
        lim_q <= seg_limit;
      end
      if (state == CHECK) begin
        pe_q  <= prot;
        pf_q  <= 1'b0;
        pfn_q <= prot ? '0 : hit_pfn;
      end
      if (state == WALK && walk_ack) begin
        pf_q  <= walk_fault;
        pfn_q <= walk_fault ? '0 : walk_pfn;
      end
      if (fill) begin
        ent[victim] <= {vpn_q, walk_pfn, 1'b1, 1'b1};
        if (!any_free) rr <= rr + 1'b1;
      end
      if (flush) for (int k = 0; k < ENTRIES; k++) ent[k][ENT_VALID] <= 1'b0;
      drop <= (state == RESP) ? 1'b0 : (drop | (flush && state == WALK));
    end
  end
endmodule
